bht_update_ctrl: RTL and testbench

Sequencer for the branch history table's write port. Sweeps every table entry to WEAKLY_NOT_TAKEN after reset or on a clear request. Buffers ID-stage resolved-branch updates in a small FIFO and retires one per cycle as a read-modify-write of the 2-bit saturating counter. Sits between the ID-stage control-flow resolution and the table storage; the table itself keeps its combinational predict read for IF.

---
 rtl/bht_update_ctrl.sv | 147 ++++++++++++++
 tb/tb_bht_update_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_update_ctrl.sv
// Write-port sequencer for the branch history table: reset/clear sweep plus a FIFO of
// resolved-branch updates, each retired as a 2-bit counter RMW. Option: BHT_UPD_BYPASS_EN.
module bht_update_ctrl #(
    parameter int unsigned INDEX_WIDTH = 6,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear_req,
    input  logic                           upd_valid,
    output logic                           upd_ready,
    input  logic [31:0]                    upd_pc,
    input  logic                           upd_taken,
    output logic [INDEX_WIDTH-1:0]         tbl_rd_index,
    input  logic [1:0]                     tbl_rd_state,
    output logic                           tbl_wr_en,
    output logic [INDEX_WIDTH-1:0]         tbl_wr_index,
    output logic [1:0]                     tbl_wr_state,
    output logic                           init_busy,
    output logic [$clog2(QUEUE_DEPTH):0]   q_count
);

    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [INDEX_WIDTH-1:0] LastIdx = {INDEX_WIDTH{1'b1}};
    localparam logic [1:0] Wnt = 2'b01;

    typedef enum logic {StInit, StRun} state_e;

    state_e                 state_q;
    logic [INDEX_WIDTH-1:0] sweep_q;
    logic [INDEX_WIDTH-1:0] idx_q   [QUEUE_DEPTH];
    logic                   taken_q [QUEUE_DEPTH];
    logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]        count_q, count_d;
    logic [INDEX_WIDTH-1:0] last_rd_q;

    logic                   run, empty, full, push, pop, byp;
    logic [INDEX_WIDTH-1:0] upd_idx, head_idx;
    logic                   head_taken;
    logic                   unused_pc;

    assign unused_pc = ^{upd_pc[31:2+INDEX_WIDTH], upd_pc[1:0]};

    function automatic logic [1:0] sat_update(input logic [1:0] s, input logic t);
        logic [1:0] r;
        r = s;
        if (t && s != 2'b11) r = s + 2'd1;
        else if (!t && s != 2'b00) r = s - 2'd1;
        return r;
    endfunction

    assign run        = (state_q == StRun) && !rst;
    assign empty      = (count_q == '0);
    assign full       = (count_q == CntW'(QUEUE_DEPTH));
    assign upd_idx    = upd_pc[2 +: INDEX_WIDTH];
    assign head_idx   = idx_q[rd_ptr_q];
    assign head_taken = taken_q[rd_ptr_q];

`ifdef BHT_UPD_BYPASS_EN
    assign byp = run && empty && upd_valid && !clear_req;
`else
    assign byp = 1'b0;
`endif

    // A clear in the same cycle drops both the incoming push and the pending retire.
    assign pop       = run && !empty && !clear_req;
    assign push      = run && upd_valid && !full && !clear_req && !byp;
    assign upd_ready = run && !full;
    assign init_busy = rst || (state_q == StInit);
    assign q_count   = count_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) count_d = count_q + CntW'(1);
        else if (pop && !push) count_d = count_q - CntW'(1);
    end

    always_comb begin
        tbl_rd_index = last_rd_q;
        if (run && !empty) tbl_rd_index = head_idx;
        else if (byp) tbl_rd_index = upd_idx;

        tbl_wr_en    = 1'b0;
        tbl_wr_index = tbl_rd_index;
        tbl_wr_state = Wnt;
        if (!rst && state_q == StInit) begin
            tbl_wr_en    = 1'b1;
            tbl_wr_index = sweep_q;
        end else if (pop) begin
            tbl_wr_en    = 1'b1;
            tbl_wr_index = head_idx;
            tbl_wr_state = sat_update(tbl_rd_state, head_taken);
        end else if (byp) begin
            tbl_wr_en    = 1'b1;
            tbl_wr_index = upd_idx;
            tbl_wr_state = sat_update(tbl_rd_state, upd_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            idx_q[wr_ptr_q]   <= upd_idx;
            taken_q[wr_ptr_q] <= upd_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StInit;
            sweep_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            last_rd_q <= '0;
        end else begin
            last_rd_q <= tbl_rd_index;
            unique case (state_q)
                StInit: begin
                    if (clear_req) begin
                        sweep_q <= '0;
                    end else if (sweep_q == LastIdx) begin
                        sweep_q <= '0;
                        state_q <= StRun;
                    end else begin
                        sweep_q <= sweep_q + 1'b1;
                    end
                end
                StRun: begin
                    if (clear_req) begin
                        state_q  <= StInit;
                        sweep_q  <= '0;
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        count_q  <= '0;
                    end else begin
                        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
                        count_q <= count_d;
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Randomized bench for bht_update_ctrl against a queue/array reference model of the
// update sequencer, plus literal checks on sweep length, saturation and bypass latency.
module tb_bht_update_ctrl;

    localparam int IW = 6;
    localparam int QD = 4;
    localparam int NE = 1 << IW;
`ifdef BHT_UPD_BYPASS_EN
    localparam int Byp = 1;
`else
    localparam int Byp = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear_req = 1'b0;
    logic          upd_valid = 1'b0;
    logic          upd_ready;
    logic [31:0]   upd_pc = '0;
    logic          upd_taken = 1'b0;
    logic [IW-1:0] tbl_rd_index;
    logic [1:0]    tbl_rd_state;
    logic          tbl_wr_en;
    logic [IW-1:0] tbl_wr_index;
    logic [1:0]    tbl_wr_state;
    logic          init_busy;
    logic [$clog2(QD):0] q_count;

    always #5 clk = ~clk;

    bht_update_ctrl #(.INDEX_WIDTH(IW), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .rst(rst), .clear_req(clear_req),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .tbl_rd_index(tbl_rd_index), .tbl_rd_state(tbl_rd_state),
        .tbl_wr_en(tbl_wr_en), .tbl_wr_index(tbl_wr_index), .tbl_wr_state(tbl_wr_state),
        .init_busy(init_busy), .q_count(q_count)
    );

    // Table storage driven by the DUT's write port.
    logic [1:0] tbl [NE];
    initial for (int i = 0; i < NE; i++) tbl[i] = 2'b11;
    assign tbl_rd_state = tbl[tbl_rd_index];
    always @(posedge clk) if (tbl_wr_en) tbl[tbl_wr_index] <= tbl_wr_state;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Record of run-mode writes to one index.
    int rec_idx = -1;
    int rec[$];
    always @(posedge clk)
        if (tbl_wr_en && !init_busy && int'(tbl_wr_index) == rec_idx) rec.push_back(int'(tbl_wr_state));

    // Reference model.
    typedef struct { int idx; bit t; } upd_t;
    upd_t m_q[$];
    int   m_tbl [NE];
    bit   m_init = 1;
    int   m_sweep = 0;
    int   m_last = 0;
    bit   m_acc = 0;
    bit   chk_en = 0;

    function automatic int sat(int s, bit t);
        if (t) return (s == 3) ? 3 : s + 1;
        return (s == 0) ? 0 : s - 1;
    endfunction

    always @(negedge clk) if (chk_en) begin
        bit e_busy, e_ready, e_wen, byp, do_push;
        int e_widx, e_wst, e_ridx, pidx;
        upd_t u;
        pidx    = int'(upd_pc[2 +: IW]);
        e_busy  = rst || m_init;
        e_ready = !rst && !m_init && m_q.size() != QD;
        e_wen = 0; e_widx = 0; e_wst = 0; byp = 0; e_ridx = m_last;
        if (!rst) begin
            if (m_init) begin
                e_wen = 1; e_widx = m_sweep; e_wst = 1;
            end else begin
                if (m_q.size() > 0) e_ridx = m_q[0].idx;
                else if (Byp == 1 && upd_valid && !clear_req) begin
                    byp = 1; e_ridx = pidx;
                end
                if (!clear_req && m_q.size() > 0) begin
                    e_wen = 1; e_widx = m_q[0].idx; e_wst = sat(m_tbl[e_widx], m_q[0].t);
                end else if (byp) begin
                    e_wen = 1; e_widx = pidx; e_wst = sat(m_tbl[pidx], upd_taken);
                end
            end
        end
        chk("init_busy", init_busy, e_busy);
        chk("upd_ready", upd_ready, e_ready);
        chk("q_count", q_count, m_q.size());
        chk("tbl_wr_en", tbl_wr_en, e_wen);
        chk("tbl_rd_index", tbl_rd_index, e_ridx);
        if (e_wen) begin
            chk("tbl_wr_index", tbl_wr_index, e_widx);
            chk("tbl_wr_state", tbl_wr_state, e_wst);
            m_tbl[e_widx] = e_wst;
        end
        m_acc = 0;
        if (rst) begin
            m_init = 1; m_sweep = 0; m_q.delete(); m_last = 0;
        end else begin
            m_last = e_ridx;
            if (m_init) begin
                if (clear_req) m_sweep = 0;
                else if (m_sweep == NE - 1) begin m_sweep = 0; m_init = 0; end
                else m_sweep++;
            end else if (clear_req) begin
                m_q.delete(); m_init = 1; m_sweep = 0;
            end else begin
                do_push = upd_valid && e_ready && !byp;
                if (byp) m_acc = 1;
                if (!byp && m_q.size() > 0) void'(m_q.pop_front());
                if (do_push) begin
                    u.idx = pidx; u.t = upd_taken;
                    m_q.push_back(u); m_acc = 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        upd_valid = 0;
        repeat (n) step();
    endtask

    task automatic push(input logic [31:0] pc, input logic t);
        bit ok;
        ok = 0;
        upd_valid = 1; upd_pc = pc; upd_taken = t;
        for (int k = 0; k < 200; k++) begin
            step();
            if (m_acc) begin ok = 1; break; end
        end
        if (!ok) begin failures++; checks++; $display("FAIL push_timeout pc=%0h", pc); end
        upd_valid = 0;
    endtask

    // Counts sweep writes from the current cycle until the first run-mode cycle.
    task automatic count_sweep(input string nm);
        int n;
        bit done;
        n = 0; done = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!init_busy) begin done = 1; break; end
            if (tbl_wr_en) n++;
        end
        chk({nm, "_done"}, done, 1);
        chk({nm, "_writes"}, n, NE);
        chk({nm, "_ready_after"}, upd_ready, 1);
        step();
    endtask

    task automatic chk_rec(input string nm, input int exp[$]);
        chk({nm, "_len"}, rec.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rec.size(); i++) chk(nm, rec[i], exp[i]);
        rec.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int e[$];
        logic [31:0] pc;
        @(posedge clk); #1;
        chk_en = 1;
        step();
        rst = 0;
        count_sweep("reset_sweep");

        // Saturation at index 16 starting from WNT.
        rec_idx = 16;
        for (int i = 0; i < 4; i++) push(32'h0000_0040, 1'b1);
        for (int i = 0; i < 5; i++) push(32'h0000_0040, 1'b0);
        idle(3);
        e = '{2, 3, 3, 3, 2, 1, 0, 0, 0};
        chk_rec("saturate", e);

        // Back-to-back taken updates to index 5.
        rec_idx = 5;
        push(32'h0000_0014, 1'b1);
        push(32'h0000_0014, 1'b1);
        idle(3);
        e = '{2, 3};
        chk_rec("same_index", e);
        rec_idx = -1;

        // Write latency for a single update into an empty queue.
        upd_valid = 1; upd_pc = 32'h0000_0080; upd_taken = 1;
        @(negedge clk);
        chk("accept_cycle_wr_en", tbl_wr_en, Byp);
        step();
        upd_valid = 0;
        @(negedge clk);
        chk("next_cycle_wr_en", tbl_wr_en, 1 - Byp);
        chk("next_cycle_q_count", q_count, 1 - Byp);
        idle(2);

        // Consecutive pushes.
        for (int i = 0; i < 6; i++) push(32'h100 + 32'(i * 4), i[0]);
        idle(4);

        // Clear with a pending entry and a same-cycle push.
        push(32'h0000_0020, 1'b1);
        upd_valid = 1; upd_pc = 32'h0000_0024; upd_taken = 1; clear_req = 1;
        step();
        clear_req = 0; upd_valid = 0;
        count_sweep("clear_sweep");

        // Randomized traffic with occasional clear and reset.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 699) == 0);
            clear_req = ($urandom_range(0, 199) == 0);
            if (!(upd_valid && !m_acc)) begin
                upd_valid = ($urandom_range(0, 2) != 0);
                pc = $urandom;
                pc[2 +: IW] = IW'($urandom_range(0, 7));
                upd_pc = pc;
                upd_taken = $urandom_range(0, 1);
            end
            step();
        end
        rst = 0; clear_req = 0;
        idle(NE + 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
